// File: rtl/adres_pe_pkg.sv
// Shared types and sizing helpers for the multi-context ADRES processing element.
// Context header fields are unpacked into a fixed-width struct (selectors up to 5 bits).
package adres_pe_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_ADD   = 4'd1,
        OP_SUB   = 4'd2,
        OP_MUL   = 4'd3,
        OP_DIV   = 4'd4,
        OP_AND   = 4'd5,
        OP_OR    = 4'd6,
        OP_XOR   = 4'd7,
        OP_SHL   = 4'd8,
        OP_ASHR  = 4'd9,
        OP_LSHR  = 4'd10,
        OP_PASSA = 4'd11,
        OP_RSV12 = 4'd12,
        OP_RSV13 = 4'd13,
        OP_RSV14 = 4'd14,
        OP_RSV15 = 4'd15
    } adres_op_e;

    localparam int SEL_MAX_W = 5;
    localparam int HDR_MAX_W = 3 * SEL_MAX_W + 1 + 4;

    typedef struct packed {
        logic [SEL_MAX_W-1:0] sel_a;
        logic [SEL_MAX_W-1:0] sel_b;
        logic [SEL_MAX_W-1:0] sel_route;
        logic                 out_sel;
        adres_op_e            op;
    } ctx_fields_t;

    function automatic int f_sa(input int num_in);
        return $clog2(num_in + 2);
    endfunction

    function automatic int f_sb(input int num_in);
        return $clog2(num_in + 1);
    endfunction

    function automatic int f_cb(input int contexts);
        return $clog2(contexts);
    endfunction

    function automatic int f_wctx(input int num_in, input int width);
        return f_sa(num_in) + 2 * f_sb(num_in) + 1 + 4 + width;
    endfunction

    // Header is the context word minus its trailing constant, LSB aligned.
    function automatic ctx_fields_t f_unpack(
        input logic [HDR_MAX_W-1:0] hdr,
        input int                   sa,
        input int                   sb
    );
        logic [HDR_MAX_W-1:0] w;
        ctx_fields_t          f;
        w           = hdr;
        f.sel_a     = w[SEL_MAX_W-1:0] & ((SEL_MAX_W'(1) << sa) - SEL_MAX_W'(1));
        w           = w >> sa;
        f.sel_b     = w[SEL_MAX_W-1:0] & ((SEL_MAX_W'(1) << sb) - SEL_MAX_W'(1));
        w           = w >> sb;
        f.sel_route = w[SEL_MAX_W-1:0] & ((SEL_MAX_W'(1) << sb) - SEL_MAX_W'(1));
        w           = w >> sb;
        f.out_sel   = w[0];
        w           = w >> 1;
        f.op        = adres_op_e'(w[3:0]);
        return f;
    endfunction

endpackage

// File: rtl/adres_pe_alu.sv
// Combinational ALU of the ADRES PE.
// Define ADRES_PE_DIVIDE_EN to build the unsigned divider (opcode 4); otherwise it yields 0.
module adres_alu
    import adres_pe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  adres_op_e        i_op,
    output logic [WIDTH-1:0] o_y
);

    localparam int SH = $clog2(WIDTH);

    logic [SH-1:0] w_sh;

    assign w_sh = i_b[SH-1:0];

    always_comb begin
        o_y = '0;
        unique case (i_op)
            OP_ADD:   o_y = i_a + i_b;
            OP_SUB:   o_y = i_a - i_b;
            OP_MUL:   o_y = i_a * i_b;
`ifdef ADRES_PE_DIVIDE_EN
            OP_DIV:   o_y = (i_b == '0) ? '1 : i_a / i_b;
`else
            OP_DIV:   o_y = '0;
`endif
            OP_AND:   o_y = i_a & i_b;
            OP_OR:    o_y = i_a | i_b;
            OP_XOR:   o_y = i_a ^ i_b;
            OP_SHL:   o_y = i_a << w_sh;
            OP_ASHR:  o_y = $signed(i_a) >>> w_sh;
            OP_LSHR:  o_y = i_a >> w_sh;
            OP_PASSA: o_y = i_a;
            default:  o_y = '0;
        endcase
    end

endmodule

// File: rtl/multi_context_adres_pe.sv
// Multi-context ADRES PE: serial config chain, modulo context counter, registered datapath.
// Optional divider via ADRES_PE_DIVIDE_EN (handled inside adres_alu).
module multi_context_adres_pe
    import adres_pe_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NUM_IN   = 8,
    parameter int CONTEXTS = 4
) (
    input  logic                        CGRA_Clock,
    input  logic                        CGRA_Reset,
    input  logic                        ConfigEnable,
    input  logic                        ConfigIn,
    output logic                        ConfigOut,
    input  logic                        run,
    input  logic [NUM_IN*WIDTH-1:0]     in,
    input  logic [WIDTH-1:0]            rf_in_muxa,
    input  logic [WIDTH-1:0]            rf_in_muxout,
    output logic [WIDTH-1:0]            out,
    output logic [WIDTH-1:0]            rf_out,
    output logic [$clog2(CONTEXTS)-1:0] ctx
);

    localparam int SA    = f_sa(NUM_IN);
    localparam int SB    = f_sb(NUM_IN);
    localparam int CB    = f_cb(CONTEXTS);
    localparam int W_CTX = f_wctx(NUM_IN, WIDTH);
    localparam int HDR_W = W_CTX - WIDTH;
    localparam int L     = CB + CONTEXTS * W_CTX;

    logic [L-1:0]       r_chain;
    logic [CB-1:0]      r_ctx;
    logic [WIDTH-1:0]   r_out;
    logic [WIDTH-1:0]   r_rf_out;

    logic [W_CTX-1:0]   w_words [CONTEXTS];
    logic [WIDTH-1:0]   w_lane  [NUM_IN];
    logic [W_CTX-1:0]   w_word;
    logic [CB-1:0]      w_ii_m1;
    logic [WIDTH-1:0]   w_const;
    ctx_fields_t        w_f;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [WIDTH-1:0]   w_r;
    logic [WIDTH-1:0]   w_alu;
    logic [WIDTH-1:0]   w_out_val;

    for (genvar k = 0; k < CONTEXTS; k++) begin : g_words
        assign w_words[k] = r_chain[CB + k*W_CTX +: W_CTX];
    end

    for (genvar k = 0; k < NUM_IN; k++) begin : g_lanes
        assign w_lane[k] = in[k*WIDTH +: WIDTH];
    end

    assign w_ii_m1 = r_chain[CB-1:0];
    assign w_word  = w_words[r_ctx];
    assign w_const = w_word[W_CTX-1 -: WIDTH];
    assign w_f     = f_unpack(HDR_MAX_W'(w_word[HDR_W-1:0]), SA, SB);

    // Selector codes past the lanes pick const, then rf_in_muxa (A only), else zero.
    always_comb begin
        w_a = '0;
        w_b = '0;
        w_r = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (int'(w_f.sel_a) == k)     w_a = w_lane[k];
            if (int'(w_f.sel_b) == k)     w_b = w_lane[k];
            if (int'(w_f.sel_route) == k) w_r = w_lane[k];
        end
        if (int'(w_f.sel_a) == NUM_IN)     w_a = w_const;
        if (int'(w_f.sel_a) == NUM_IN + 1) w_a = rf_in_muxa;
        if (int'(w_f.sel_b) == NUM_IN)     w_b = w_const;
        if (int'(w_f.sel_route) == NUM_IN) w_r = w_const;
    end

    assign w_out_val = w_f.out_sel ? rf_in_muxout : w_r;

    adres_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .i_a  (w_a),
        .i_b  (w_b),
        .i_op (w_f.op),
        .o_y  (w_alu)
    );

    always_ff @(posedge CGRA_Clock or posedge CGRA_Reset) begin
        if (CGRA_Reset) begin
            r_chain <= '0;
        end else if (ConfigEnable) begin
            r_chain <= {ConfigIn, r_chain[L-1:1]};
        end
    end

    always_ff @(posedge CGRA_Clock or posedge CGRA_Reset) begin
        if (CGRA_Reset) begin
            r_ctx    <= '0;
            r_out    <= '0;
            r_rf_out <= '0;
        end else if (ConfigEnable) begin
            r_ctx    <= '0;
        end else if (run) begin
            r_ctx    <= (r_ctx == w_ii_m1) ? '0 : r_ctx + CB'(1);
            r_out    <= w_out_val;
            r_rf_out <= w_alu;
        end
    end

    assign ConfigOut = r_chain[0];
    assign ctx       = r_ctx;
    assign out       = r_out;
    assign rf_out    = r_rf_out;

endmodule

// File: tb/tb_multi_context_adres_pe.sv
// Randomized bench for multi_context_adres_pe with an in-bench behavioural model.
// Model tracks the config chain bit-serially and evaluates each context from the field layout.
module tb_multi_context_adres_pe;

    localparam int WIDTH    = 32;
    localparam int NUM_IN   = 8;
    localparam int CONTEXTS = 4;
    localparam int SA = $clog2(NUM_IN + 2);
    localparam int SB = $clog2(NUM_IN + 1);
    localparam int CB = $clog2(CONTEXTS);
    localparam int WC = SA + 2 * SB + 5 + WIDTH;
    localparam int L  = CB + CONTEXTS * WC;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    cen;
    logic                    cin;
    logic                    cout;
    logic                    run;
    logic [NUM_IN*WIDTH-1:0] in_bus;
    logic [WIDTH-1:0]        muxa;
    logic [WIDTH-1:0]        muxout;
    logic [WIDTH-1:0]        out_v;
    logic [WIDTH-1:0]        rf_v;
    logic [CB-1:0]           ctx_v;

    always #5 clk = ~clk;

    multi_context_adres_pe #(
        .WIDTH    (WIDTH),
        .NUM_IN   (NUM_IN),
        .CONTEXTS (CONTEXTS)
    ) dut (
        .CGRA_Clock   (clk),
        .CGRA_Reset   (rst),
        .ConfigEnable (cen),
        .ConfigIn     (cin),
        .ConfigOut    (cout),
        .run          (run),
        .in           (in_bus),
        .rf_in_muxa   (muxa),
        .rf_in_muxout (muxout),
        .out          (out_v),
        .rf_out       (rf_v),
        .ctx          (ctx_v)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [L-1:0]     m_chain;
    logic [CB-1:0]    m_ctx;
    logic [WIDTH-1:0] m_out;
    logic [WIDTH-1:0] m_rf;

    int               c_ii;
    int               c_sa [CONTEXTS];
    int               c_sb [CONTEXTS];
    int               c_sr [CONTEXTS];
    int               c_os [CONTEXTS];
    int               c_op [CONTEXTS];
    logic [WIDTH-1:0] c_k  [CONTEXTS];

    task automatic check(input string nm, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [WIDTH-1:0] pick(input int sel, input bit rf_ok,
                                              input logic [WIDTH-1:0] k);
        if (sel < NUM_IN) return in_bus[sel*WIDTH +: WIDTH];
        if (sel == NUM_IN) return k;
        if (rf_ok && sel == NUM_IN + 1) return muxa;
        return '0;
    endfunction

    function automatic logic [WIDTH-1:0] alu(input int op, input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
        int sh;
        sh = int'(b % WIDTH);
        case (op)
            1:  return a + b;
            2:  return a - b;
            3:  return a * b;
`ifdef ADRES_PE_DIVIDE_EN
            4:  return (b == 0) ? {WIDTH{1'b1}} : a / b;
`else
            4:  return '0;
`endif
            5:  return a & b;
            6:  return a | b;
            7:  return a ^ b;
            8:  return a << sh;
            9:  return $signed(a) >>> sh;
            10: return a >> sh;
            11: return a;
            default: return '0;
        endcase
    endfunction

    task automatic model_reset();
        m_chain = '0;
        m_ctx   = '0;
        m_out   = '0;
        m_rf    = '0;
    endtask

    task automatic model_edge();
        int base, sa, sb, sr, os, op;
        logic [WIDTH-1:0] k;
        if (cen) begin
            m_chain = {cin, m_chain[L-1:1]};
            m_ctx   = '0;
        end else if (run) begin
            base = CB + int'(m_ctx) * WC;
            sa   = int'(m_chain[base +: SA]);
            sb   = int'(m_chain[base + SA +: SB]);
            sr   = int'(m_chain[base + SA + SB +: SB]);
            os   = int'(m_chain[base + SA + 2*SB]);
            op   = int'(m_chain[base + SA + 2*SB + 1 +: 4]);
            k    = m_chain[base + SA + 2*SB + 5 +: WIDTH];
            m_rf  = alu(op, pick(sa, 1'b1, k), pick(sb, 1'b0, k));
            m_out = (os != 0) ? muxout : pick(sr, 1'b0, k);
            m_ctx = (int'(m_ctx) == int'(m_chain[CB-1:0])) ? '0 : m_ctx + 1'b1;
        end
    endtask

    task automatic compare();
        check("ctx", WIDTH'(ctx_v), WIDTH'(m_ctx));
        check("out", out_v, m_out);
        check("rf_out", rf_v, m_rf);
        check("ConfigOut", WIDTH'(cout), WIDTH'(m_chain[0]));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    function automatic logic [L-1:0] build();
        logic [L-1:0] p;
        int base;
        p = '0;
        p[CB-1:0] = CB'(c_ii);
        for (int k = 0; k < CONTEXTS; k++) begin
            base = CB + k * WC;
            p[base +: SA]              = SA'(c_sa[k]);
            p[base + SA +: SB]         = SB'(c_sb[k]);
            p[base + SA + SB +: SB]    = SB'(c_sr[k]);
            p[base + SA + 2*SB]        = c_os[k][0];
            p[base + SA + 2*SB + 1 +: 4] = 4'(c_op[k]);
            p[base + SA + 2*SB + 5 +: WIDTH] = c_k[k];
        end
        return p;
    endfunction

    task automatic set_ctx(input int k, input int sa, input int sb, input int sr,
                           input int os, input int op, input logic [WIDTH-1:0] kv);
        c_sa[k] = sa; c_sb[k] = sb; c_sr[k] = sr;
        c_os[k] = os; c_op[k] = op; c_k[k]  = kv;
    endtask

    task automatic clear_cfg();
        for (int k = 0; k < CONTEXTS; k++) set_ctx(k, 0, 0, 0, 0, 0, '0);
    endtask

    task automatic load();
        logic [L-1:0] p;
        p   = build();
        cen = 1'b1;
        run = 1'(($urandom % 2));
        for (int i = 0; i < L; i++) begin
            cin = p[i];
            step();
        end
        cen = 1'b0;
        cin = 1'b0;
        run = 1'b0;
    endtask

    task automatic set_lane(input int k, input logic [WIDTH-1:0] v);
        in_bus[k*WIDTH +: WIDTH] = v;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [L-1:0]     pat;
        logic [WIDTH-1:0] ea [4];
        logic [WIDTH-1:0] eb [4];
        logic [WIDTH-1:0] er [4];
        int               ec [4];

        rst = 1'b1; cen = 1'b0; cin = 1'b0; run = 1'b0;
        in_bus = '0; muxa = '0; muxout = '0;
        #1;
        check("reset_out", out_v, '0);
        check("reset_rf", rf_v, '0);
        check("reset_ctx", WIDTH'(ctx_v), '0);
        check("reset_cfgout", WIDTH'(cout), '0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Chain: pattern in, then zeros; ConfigOut must replay the pattern.
        for (int i = 0; i < L; i++) pat[i] = 1'($urandom % 2);
        cen = 1'b1;
        for (int i = 0; i < L; i++) begin
            cin = pat[i];
            step();
        end
        for (int i = 0; i < L; i++) begin
            check("chain_replay", WIDTH'(cout), WIDTH'(pat[i]));
            cin = 1'b0;
            step();
        end
        cen = 1'b0;

        // Modulo schedule with ii_m1 = 2.
        clear_cfg();
        c_ii = 2;
        set_ctx(0, 0, 1, 0, 0, 1, '0);
        set_ctx(1, 0, NUM_IN, 0, 0, 2, 32'd5);
        set_ctx(2, NUM_IN + 1, 0, 0, 0, 11, '0);
        load();
        set_lane(0, 32'd10);
        set_lane(1, 32'd3);
        muxa = 32'h77;
        run  = 1'b1;
        er = '{32'd13, 32'd5, 32'h77, 32'd13};
        ec = '{0, 1, 2, 0};
        for (int i = 0; i < 4; i++) begin
            check("sched_ctx", WIDTH'(ctx_v), WIDTH'(ec[i]));
            step();
            check("sched_rf", rf_v, er[i]);
            check("sched_out", out_v, 32'd10);
        end
        run = 1'b0;

        // Arithmetic edge cases, one per context.
        clear_cfg();
        c_ii = 3;
        set_ctx(0, 0, 1, 0, 0, 1, '0);
        set_ctx(1, 0, 1, 0, 0, 9, '0);
        set_ctx(2, 0, 1, 0, 0, 10, '0);
        set_ctx(3, 0, 1, 0, 0, 3, '0);
        load();
        ea = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h0001_0000};
        eb = '{32'd1, 32'd4, 32'd4, 32'h0001_0000};
        er = '{32'h0, 32'hF800_0000, 32'h0800_0000, 32'h0};
        run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_lane(0, ea[i]);
            set_lane(1, eb[i]);
            step();
            check("arith_rf", rf_v, er[i]);
        end
        run = 1'b0;

        // Divide, then hold and priority checks.
        clear_cfg();
        c_ii = 1;
        set_ctx(0, 0, 1, 0, 0, 4, '0);
        set_ctx(1, 0, 1, 0, 0, 4, '0);
        load();
        ea = '{32'd100, 32'd5, 32'd0, 32'd0};
        eb = '{32'd7, 32'd0, 32'd0, 32'd0};
`ifdef ADRES_PE_DIVIDE_EN
        er = '{32'd14, 32'hFFFF_FFFF, 32'd0, 32'd0};
`else
        er = '{32'd0, 32'd0, 32'd0, 32'd0};
`endif
        run = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_lane(0, ea[i]);
            set_lane(1, eb[i]);
            step();
            check("div_rf", rf_v, er[i]);
        end
        run = 1'b0;
        set_lane(0, 32'd100);
        set_lane(1, 32'd7);
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_rf", rf_v, er[1]);
            check("hold_ctx", WIDTH'(ctx_v), '0);
        end
        run = 1'b1;
        step();
        check("prio_step_ctx", WIDTH'(ctx_v), 32'd1);
        cen = 1'b1;
        cin = 1'b0;
        step();
        check("prio_ctx", WIDTH'(ctx_v), '0);
        check("prio_rf", rf_v, er[0]);
        cen = 1'b0;
        run = 1'b0;

        // Output route from rf_in_muxout.
        clear_cfg();
        c_ii = 0;
        set_ctx(0, 0, 0, 0, 1, 11, '0);
        load();
        muxout = 32'h0000_ABCD;
        run = 1'b1;
        step();
        check("outsel_out", out_v, 32'h0000_ABCD);
        run = 1'b0;

        // Randomized configurations and traffic.
        for (int r = 0; r < 8; r++) begin
            c_ii = int'($urandom % CONTEXTS);
            for (int k = 0; k < CONTEXTS; k++)
                set_ctx(k, int'($urandom % (1 << SA)), int'($urandom % (1 << SB)),
                        int'($urandom % (1 << SB)), int'($urandom % 2),
                        int'($urandom % 16),
                        ($urandom % 4 == 0) ? WIDTH'($urandom % 4) : WIDTH'($urandom));
            load();
            for (int t = 0; t < 150; t++) begin
                for (int k = 0; k < NUM_IN; k++)
                    set_lane(k, ($urandom % 4 == 0) ? WIDTH'($urandom % 8) : WIDTH'($urandom));
                muxa   = $urandom;
                muxout = $urandom;
                run    = ($urandom % 4) != 0;
                cen    = ($urandom % 40) == 0;
                cin    = 1'($urandom % 2);
                step();
            end
            cen = 1'b0;
            if (r == 5) begin
                #2;
                rst = 1'b1;
                #1;
                check("midrun_reset_out", out_v, '0);
                check("midrun_reset_rf", rf_v, '0);
                check("midrun_reset_ctx", WIDTH'(ctx_v), '0);
                check("midrun_reset_cfgout", WIDTH'(cout), '0);
                model_reset();
                rst = 1'b0;
                step();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
